// File: rtl/counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : counter
// Description : Parameterised synchronous up/down binary counter with a
//               synchronous active-low reset. dir = 0 counts up, dir = 1
//               counts down. Q comes straight from the state register.
//               Optional macro COUNTER_SATURATE_EN: when defined, the count
//               clamps at all-ones (up) and zero (down) instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             dir,
    input  logic             reset,
    output logic [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONES = '1;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    // Next-count selection: step by one in the requested direction
    always_comb begin
        w_next = r_q;
        if (dir == 1'b0) begin
`ifdef COUNTER_SATURATE_EN
            // Clamp at all-ones rather than rolling over to zero
            w_next = (r_q == C_ONES) ? r_q : (r_q + C_ONE);
`else
            // Plain modulo add; the carry out is discarded
            w_next = r_q + C_ONE;
`endif
        end else begin
`ifdef COUNTER_SATURATE_EN
            // Clamp at zero rather than rolling under to all-ones
            w_next = (r_q == C_ZERO) ? r_q : (r_q - C_ONE);
`else
            // Plain modulo subtract; the borrow out is discarded
            w_next = r_q - C_ONE;
`endif
        end
    end

    // State register: reset is sampled on the clock edge only
    always_ff @(posedge clk) begin
        if (reset == 1'b0) begin
            r_q <= C_ZERO;
        end else begin
            r_q <= w_next;
        end
    end

    assign Q = r_q;

endmodule
`default_nettype wire

// File: tb/tb_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_counter
// Description : Directed self-checking bench for counter (WIDTH = 4).
//               Expected values follow the saturating variant when
//               COUNTER_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter;

    logic       clk;
    logic       dir;
    logic       reset;
    logic [3:0] Q;

    int checks = 0;
    int errors = 0;

    counter #(
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .dir   (dir),
        .reset (reset),
        .Q     (Q)
    );

    // 2-unit clock period; rising edges at t = 1, 3, 5, ...
    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Advance one rising edge, then return on the following falling edge so
    // that sampling and input changes happen away from the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [3:0] exp);
        checks++;
        assert (Q === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, Q, exp);
        end
    endtask

    initial begin
        dir   = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Reset and up-count
        tick();
        check("reset_value", 4'd0);
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("up_count", 4'(i));
        end

        // Up wrap: continue from 7 to 15, then one more edge
        for (int i = 8; i <= 15; i++) begin
            tick();
            check("up_to_max", 4'(i));
        end
        tick();
`ifdef COUNTER_SATURATE_EN
        check("up_wrap", 4'd15);
        tick();
        check("up_hold", 4'd15);
`else
        check("up_wrap", 4'd0);
        tick();
        check("up_after_wrap", 4'd1);
`endif

        // Down-count and wrap from reset
        reset = 1'b0;
        dir   = 1'b1;
        tick();
        check("reset_dir1", 4'd0);
        reset = 1'b1;
        tick();
`ifdef COUNTER_SATURATE_EN
        check("down_wrap0", 4'd0);
        tick();
        check("down_wrap1", 4'd0);
        tick();
        check("down_wrap2", 4'd0);
`else
        check("down_wrap0", 4'd15);
        tick();
        check("down_wrap1", 4'd14);
        tick();
        check("down_wrap2", 4'd13);
`endif

        // Direction change: up to 5 then down
        reset = 1'b0;
        dir   = 1'b0;
        tick();
        check("reset_dirchg", 4'd0);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
        end
        check("up_to_5", 4'd5);
        dir = 1'b1;
        tick();
        check("dirchg_down1", 4'd4);
        tick();
        check("dirchg_down2", 4'd3);
        dir = 1'b0;
        tick();
        check("dirchg_up_again", 4'd4);

        // Reset mid-count at 9
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
        end
        check("up_to_9", 4'd9);
        reset = 1'b0;
        dir   = 1'b1;
        tick();
        check("mid_reset", 4'd0);
        reset = 1'b1;
        dir   = 1'b0;
        tick();
        check("after_mid_reset", 4'd1);

        // Reset pulse between edges must be ignored
        #0.3 reset = 1'b0;
        #0.4 reset = 1'b1;
        tick();
        check("glitch_ignored", 4'd2);
        tick();
        check("glitch_continue", 4'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
